// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD CMD-line host and its CRC7 helper.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package sd_cmd_pkg;

    // Transaction phases of the CMD-line host.
    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_TX,
        ST_NCR,
        ST_RX,
        ST_NCC
    } state_t;

    // Response type encodings on rsp_type_i. RSP_RSVD behaves like RSP_NONE.
    localparam logic [1:0] RSP_NONE  = 2'd0;
    localparam logic [1:0] RSP_SHORT = 2'd1;
    localparam logic [1:0] RSP_LONG  = 2'd2;
    localparam logic [1:0] RSP_RSVD  = 2'd3;

    // Frame lengths on the wire, in bits.
    localparam int FRAME_SHORT = 48;
    localparam int FRAME_LONG  = 136;

    // x^7 + x^3 + 1, with the x^7 term implicit.
    localparam logic [6:0] CRC7_POLY = 7'h09;

    // Bit positions inside status_o.
    localparam int STAT_TIMEOUT = 0;
    localparam int STAT_CRC_ERR = 1;
    localparam int STAT_IDX_ERR = 2;
    localparam int STAT_END_ERR = 3;

    // One serial CRC7 step: shift the register and fold in the feedback term.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 accumulator, shared by the transmit and receive paths.
// Latency: the CRC of the bits fed so far is visible one clock after the last en_i.
// Backpressure: none; bits are consumed whenever en_i is high, clr_i wins over en_i.
//
// Ports:
//   clk_i    : clock, rising edge
//   clr_i    : synchronous clear to 0 (also used as the reset path)
//   en_i     : accumulate bit_in_i this cycle
//   bit_in_i : serial data bit
//   crc_o    : current CRC7 register
module sd_crc7_serial
    import sd_cmd_pkg::*;
(
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_in_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = 7'h00;
        end else if (en_i) begin
            crc_d = crc7_step(crc_q, bit_in_i);
        end
    end

    always_ff @(posedge clk_i) begin
        crc_q <= crc_d;
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_host_param.sv
// SD CMD-line host: serialises a 48-bit command with CRC7, optionally captures and checks a response.
// Latency: first frame bit on the cycle after accept; done_o 48+NCC_CYCLES clocks after accept when no response.
// Backpressure: cmd_ready_o is high only in IDLE; cmd_valid_i at any other time is dropped, never queued.
//
// Ports:
//   SD_CLK_IN, RST_IN (sync, active high), GO_IDLE (sync abort to IDLE, no re-init)
//   cmd_valid_i/cmd_ready_o, cmd_i {xx, index, arg}, rsp_type_i, crc_chk_i, idx_chk_i : command request
//   cmd_dat_i, cmd_out_o, cmd_oe_o : CMD pad
//   done_o (1-cycle pulse), rsp_data_o, status_o {end_err, idx_err, crc_err, timeout} : result
module sd_cmd_host_param
    import sd_cmd_pkg::*;
#(
    parameter int INIT_CYCLES = 80,
    parameter int NCR_MAX     = 64,
    parameter int NCC_CYCLES  = 8,
    parameter int CNT_W       = 8
) (
    input  logic         SD_CLK_IN,
    input  logic         RST_IN,
    input  logic         GO_IDLE,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [39:0]  cmd_i,
    input  logic [1:0]   rsp_type_i,
    input  logic         crc_chk_i,
    input  logic         idx_chk_i,
    input  logic         cmd_dat_i,
    output logic         cmd_out_o,
    output logic         cmd_oe_o,
    output logic         done_o,
    output logic [127:0] rsp_data_o,
    output logic [3:0]   status_o
);

    // Counter terminal values.
    localparam logic [CNT_W-1:0] INIT_LAST      = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] NCR_LAST       = CNT_W'(NCR_MAX - 1);
    localparam logic [CNT_W-1:0] NCC_LAST       = CNT_W'(NCC_CYCLES - 1);
    localparam logic [CNT_W-1:0] TX_LAST        = CNT_W'(FRAME_SHORT - 1);
    // Index of the first TX cycle that carries CRC instead of header/argument.
    localparam logic [CNT_W-1:0] TX_CRC_FIRST   = CNT_W'(FRAME_SHORT - 8);
    // The start bit is taken in NCR, so RX counts N-1 bits: frame bit = N-2-cnt.
    localparam logic [CNT_W-1:0] SHORT_RX_LAST  = CNT_W'(FRAME_SHORT - 2);
    localparam logic [CNT_W-1:0] LONG_RX_LAST   = CNT_W'(FRAME_LONG - 2);
    // CRC windows in RX count units: short covers bits 46..8, long covers 127..8.
    localparam logic [CNT_W-1:0] SHORT_CRC_END  = CNT_W'(FRAME_SHORT - 10);
    localparam logic [CNT_W-1:0] LONG_CRC_START = CNT_W'(FRAME_LONG - 2 - 127);
    localparam logic [CNT_W-1:0] LONG_CRC_END   = CNT_W'(FRAME_LONG - 10);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [39:0]        tx_sh_q, tx_sh_d;
    logic [126:0]       rx_sh_q, rx_sh_d;
    logic [5:0]         idx_q, idx_d;
    logic               rsp_en_q, rsp_en_d;
    logic               rsp_long_q, rsp_long_d;
    logic               crc_chk_q, crc_chk_d;
    logic               idx_chk_q, idx_chk_d;
    logic [127:0]       rsp_data_q, rsp_data_d;
    logic [3:0]         status_q, status_d;
    logic               done_q, done_d;

    logic               crc_clr;
    logic               crc_en;
    logic               crc_bit;
    logic [6:0]         crc;
    logic [7:0]         tx_tail;
    logic               rx_last;
    logic               rx_crc_win;
    logic               oe;
    logic               out_bit;
    logic               ready;

    // The two framing bits of cmd_i are replaced by the fixed 2'b01 prefix.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^cmd_i[39:38];

    sd_crc7_serial u_crc (
        .clk_i    (SD_CLK_IN),
        .clr_i    (crc_clr | RST_IN | GO_IDLE),
        .en_i     (crc_en),
        .bit_in_i (crc_bit),
        .crc_o    (crc)
    );

    // CRC7 followed by the end bit; walked MSB first by the low 3 counter bits,
    // which run 0..7 over TX counts 40..47.
    assign tx_tail = {crc, 1'b1};

    assign rx_last    = rsp_long_q ? (cnt_q == LONG_RX_LAST) : (cnt_q == SHORT_RX_LAST);
    assign rx_crc_win = rsp_long_q ? ((cnt_q >= LONG_CRC_START) && (cnt_q <= LONG_CRC_END))
                                   : (cnt_q <= SHORT_CRC_END);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        idx_d      = idx_q;
        rsp_en_d   = rsp_en_q;
        rsp_long_d = rsp_long_q;
        crc_chk_d  = crc_chk_q;
        idx_chk_d  = idx_chk_q;
        rsp_data_d = rsp_data_q;
        status_d   = status_q;
        done_d     = 1'b0;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        crc_bit    = 1'b0;
        oe         = 1'b0;
        out_bit    = 1'b1;
        ready      = 1'b0;

        case (state_q)
            ST_INIT: begin
                oe = 1'b1;
                if (cnt_q == INIT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_IDLE: begin
                ready = 1'b1;
                if (cmd_valid_i) begin
                    tx_sh_d    = {2'b01, cmd_i[37:0]};
                    idx_d      = cmd_i[37:32];
                    rsp_en_d   = (rsp_type_i == RSP_SHORT) || (rsp_type_i == RSP_LONG);
                    rsp_long_d = (rsp_type_i == RSP_LONG);
                    crc_chk_d  = crc_chk_i;
                    idx_chk_d  = idx_chk_i;
                    status_d   = 4'h0;
                    crc_clr    = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_TX;
                end
            end

            ST_TX: begin
                oe = 1'b1;
                if (cnt_q < TX_CRC_FIRST) begin
                    // Header/argument bits feed the CRC as they go out, so the
                    // CRC register is complete exactly when bit 7 is due.
                    out_bit = tx_sh_q[39];
                    crc_en  = 1'b1;
                    crc_bit = tx_sh_q[39];
                    tx_sh_d = {tx_sh_q[38:0], 1'b0};
                end else begin
                    out_bit = tx_tail[3'd7 - cnt_q[2:0]];
                end
                if (cnt_q == TX_LAST) begin
                    cnt_d   = '0;
                    state_d = rsp_en_q ? ST_NCR : ST_NCC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_NCR: begin
                // Hold the CRC at zero; the start bit (0) would not change it anyway.
                crc_clr = 1'b1;
                if (!cmd_dat_i) begin
                    cnt_d   = '0;
                    state_d = ST_RX;
                end else if (cnt_q == NCR_LAST) begin
                    status_d[STAT_TIMEOUT] = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_NCC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RX: begin
                rx_sh_d = {rx_sh_q[125:0], cmd_dat_i};
                crc_en  = rx_crc_win;
                crc_bit = cmd_dat_i;
                if (rx_last) begin
                    // rx_sh_q holds frame bits N-2..1 with frame bit k at [k-1];
                    // the end bit is on cmd_dat_i this cycle.
                    if (rsp_long_q) begin
                        rsp_data_d = {rx_sh_q[126:0], 1'b0};
                    end else begin
                        rsp_data_d = {90'b0, rx_sh_q[44:7]};
                    end
                    status_d[STAT_CRC_ERR] = crc_chk_q && (crc != rx_sh_q[6:0]);
                    status_d[STAT_IDX_ERR] = idx_chk_q && !rsp_long_q && (rx_sh_q[44:39] != idx_q);
                    status_d[STAT_END_ERR] = !cmd_dat_i;
                    cnt_d   = '0;
                    state_d = ST_NCC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_NCC: begin
                if (cnt_q == NCC_LAST) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge SD_CLK_IN) begin
        if (RST_IN || GO_IDLE) begin
            // GO_IDLE clears everything like reset but skips the power-up INIT phase.
            state_q    <= RST_IN ? ST_INIT : ST_IDLE;
            cnt_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            idx_q      <= '0;
            rsp_en_q   <= 1'b0;
            rsp_long_q <= 1'b0;
            crc_chk_q  <= 1'b0;
            idx_chk_q  <= 1'b0;
            rsp_data_q <= '0;
            status_q   <= 4'h0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            idx_q      <= idx_d;
            rsp_en_q   <= rsp_en_d;
            rsp_long_q <= rsp_long_d;
            crc_chk_q  <= crc_chk_d;
            idx_chk_q  <= idx_chk_d;
            rsp_data_q <= rsp_data_d;
            status_q   <= status_d;
            done_q     <= done_d;
        end
    end

    assign cmd_ready_o = ready;
    assign cmd_oe_o    = oe;
    assign cmd_out_o   = out_bit;
    assign done_o      = done_q;
    assign rsp_data_o  = rsp_data_q;
    assign status_o    = status_q;

endmodule

// File: doc/sd_cmd_host_param.md
Name: sd_cmd_host_param

Overview:
- Parametrised successor to the SD CMD-line serial host. Serialises 48-bit SD commands with CRC7 on the CMD line and optionally captures a short (48-bit) or long (136-bit, R2) response.
- Adds response timeout (NCR), CRC7, index and end-bit checking, and an NCC turnaround gap.
- Uses a valid/ready command interface instead of REQ/ACK synchronisers.
- Sits between the SD controller command FSM and the CMD pad (cmd_out_o, cmd_oe_o, cmd_dat_i).

Parameters:
- INIT_CYCLES, 80: clocks with CMD driven high after reset (at least 74 per SD spec).
- NCR_MAX, 64: max clocks after the command end bit to wait for a response start bit.
- NCC_CYCLES, 8: idle clocks after transaction end before the next command is accepted.
- CNT_W, 8: bit/delay counter width; must hold 136 and NCR_MAX.

Ports:
- SD_CLK_IN  in  1  SD clock; all logic on the rising edge.
- RST_IN  in  1  synchronous, active-high reset.
- GO_IDLE  in  1  synchronous abort; returns to IDLE without repeating INIT.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  high only in IDLE.
- cmd_i  in  40  {2'bxx, index[5:0], arg[31:0]}; bits 39:38 ignored, sent as 2'b01.
- rsp_type_i  in  2  0 = none, 1 = short, 2 = long, 3 = reserved (treated as none).
- crc_chk_i  in  1  enable CRC7 check of the response.
- idx_chk_i  in  1  enable index check (short responses only).
- cmd_dat_i  in  1  CMD line input.
- cmd_out_o  out  1  CMD line output value.
- cmd_oe_o  out  1  CMD line output enable.
- done_o  out  1  one-cycle pulse at transaction end.
- rsp_data_o  out  128  captured response.
- status_o  out  4  {end_err, idx_err, crc_err, timeout}.

Behaviour:
- Reset values: cmd_out_o = 1, cmd_oe_o = 1, cmd_ready_o = 0, done_o = 0, rsp_data_o = 0, status_o = 0, state INIT, counters 0.
- GO_IDLE: same register values as reset except state IDLE and cmd_oe_o = 0. RST_IN has priority if both are asserted.
- INIT: hold cmd_oe_o = 1 and cmd_out_o = 1 for INIT_CYCLES clocks, then go to IDLE.
- IDLE: cmd_oe_o = 0, cmd_ready_o = 1.
  - When cmd_valid_i & cmd_ready_o: latch cmd_i, rsp_type_i, crc_chk_i and idx_chk_i; clear status_o; go to TX.
  - rsp_data_o holds its previous value until the next accept.
- TX: 48 cycles with cmd_oe_o = 1.
  - Frame order is MSB first: bit 47 start = 0, bit 46 = 1, index, arg, CRC7[6:0], end bit = 1.
  - The first cycle after accept drives frame bit 47.
  - CRC7 (poly x^7 + x^3 + 1, init 0) is computed over frame bits 47:8 and must be ready when bit 7 is driven. No pre-load idle cycle is allowed.
  - Last TX cycle: go to NCC if rsp_type = none, else go to NCR.
- NCR: cmd_oe_o = 0; count clocks.
  - cmd_dat_i == 0 seen: that cycle is response bit N-1 (the start bit); go to RX.
  - Counter reaches NCR_MAX with no start bit: set timeout, go to NCC.
- RX: shift in the remaining N-1 bits (N = 48 short, 136 long). CRC7 over response bits:
  - short: bits 47:8;
  - long: bits 127:8 (the first 8 bits are excluded).
- At the last RX bit:
  - short: rsp_data_o = {90'b0, frame[45:8]} (index + arg).
  - long: rsp_data_o = {frame[127:1], 1'b0}.
  - crc_err = crc_chk & (rx CRC != computed).
  - idx_err = idx_chk & short & (rx index != tx index).
  - end_err = (end bit != 1).
  - Go to NCC.
- NCC: cmd_oe_o = 0 for NCC_CYCLES clocks, then done_o pulses for one cycle and the FSM enters IDLE in the same transition.
- Boundaries:
  - A start bit seen on the very first NCR cycle is valid (Ncr = 0).
  - cmd_valid_i outside IDLE is ignored (not queued).
  - GO_IDLE mid-TX forces cmd_oe_o = 0 on the next edge and produces no done_o.
  - status_o is stable from done_o until the next accept.

Decomposition:
- Package sd_cmd_pkg: state enum (INIT, IDLE, TX, NCR, RX, NCC), rsp_type encodings, frame lengths 48 and 136, CRC7 polynomial, status bit indices.
- Sub-module sd_crc7_serial (clr, en, bit_in, crc[6:0]), instantiated once and shared between TX and RX.

Test Plan:
- Reset, then observe: cmd_oe_o = 1 and cmd_out_o = 1 for exactly 80 clocks; cmd_ready_o rises on cycle 81.
- CMD0 (cmd_i = 0, rsp none): serial frame = 48'h400000000095; done_o fires 48 + 8 cycles after accept; status_o = 0.
- CMD8 with arg 32'h1AA, short rsp: TX = 48'h48000001AA87; bench returns 48'h08000001AA13 after Ncr = 2. Expect rsp_data_o[37:0] = {6'h08, 32'h1AA}, status_o = 0. Repeat with a flipped CRC bit: status_o = 4'b0010.
- Short rsp with index 9 vs tx 8, idx_chk = 1: status_o = 4'b0100. Same with idx_chk = 0: status_o = 0.
- cmd_dat_i held 1: timeout after exactly 64 NCR clocks, status_o = 4'b0001, then done_o after NCC.
- Long R2 with model-generated CID frame: rsp_data_o[127:1] equals the frame. GO_IDLE asserted mid-RX: IDLE next cycle, no done_o, next command accepted normally.
